score_record_streamer: RTL and testbench
========================================

// Module: score_record_streamer
// PURPOSE
//  Transmit side of the scoreboard record link. Collects {userid,score} records from game logic
//  into a small table (one entry per userid, best score kept) and, on start, streams them out
//  as 32-bit words framed by parity_toggle edges, terminated by the score sentinel 16'hFFFF.
//  Drives data/parity_toggle of the scoreboard display block; busy/stream_done go to the top FSM.
// PARAMETERS
//  DEPTH       8        table entries (2..16); count width = clog2(DEPTH+1)
//  GAP_CYCLES  2        cycles each word is held before the next toggle (>=1)
//  SENTINEL    16'hFFFF reserved end-of-stream score value
// PORTS
//  clk           in   1   system clock, all logic on posedge
//  rst           in   1   asynchronous, active-high reset
//  wr_en         in   1   write request (one record per cycle)
//  wr_userid     in   16  record userid
//  wr_score      in   16  record score
//  clear         in   1   empty the table (IDLE only)
//  start         in   1   begin streaming the table (IDLE only)
//  data          out  32  {userid[31:16], score[15:0]} of current word
//  parity_toggle out  1   level changes once per new word on data
//  busy          out  1   high from the cycle after start until stream_done cycle inclusive
//  stream_done   out  1   one-cycle pulse at end of stream
//  wr_drop       out  1   one-cycle pulse: write rejected (full, or not IDLE)
//  count         out  5   valid entries in table
// BEHAVIOUR
//  - Reset (async, immediate): data=0, parity_toggle=0, busy=0, stream_done=0, wr_drop=0,
//    count=0, all table entries invalid, FSM=IDLE. Reset mid-stream aborts; no sentinel sent.
//  - States: IDLE -> SNAP -> SEND -> HOLD -> (SEND | TERM) ; TERM -> HOLD_T -> IDLE.
//  - Writes (IDLE only, registered; visible next cycle):
//    * score 16'hFFFF clamped to 16'hFFFE (sentinel reserved).
//    * userid matches a valid entry: entry score <= max(old,new); count unchanged.
//    * no match, count<DEPTH: append at index count; count+1.
//    * no match, count==DEPTH: dropped, wr_drop pulse next cycle.
//    * wr_en outside IDLE: dropped, wr_drop pulse; table untouched.
//  - clear in IDLE: count<=0, all entries invalid; clear beats wr_en in same cycle. Ignored outside IDLE.
//  - start in IDLE at cycle T: SNAP at T+1 latches n=count (includes a write/clear made at T);
//    busy=1 from T+1. start outside IDLE ignored.
//  - SEND: data<=table[k] (order = insertion index 0..n-1), parity_toggle inverts. Word k appears
//    at T+2+k*GAP_CYCLES and is held GAP_CYCLES cycles (HOLD counts GAP_CYCLES-1 more).
//  - TERM: data<={16'h0000,SENTINEL}, toggle at T+2+n*GAP_CYCLES; n=0 sends sentinel only.
//  - stream_done pulses at T+2+(n+1)*GAP_CYCLES, FSM->IDLE same cycle, busy drops next cycle.
//    data keeps the sentinel value; parity_toggle keeps its level (not reset between streams).
//  - Exactly n+1 toggles per stream; data never changes except in a toggle cycle.
// TESTING
//  1 rst pulse mid-cycle -> data=0, parity_toggle=0, busy=0, count=0 before next clk edge.
//  2 GAP=2; write (1,100),(2,250),(3,50); start@T -> toggles T+2/4/6 with 0x00010064,0x000200FA,
//    0x00030032; sentinel 0x0000FFFF @T+8; stream_done @T+10; 4 toggles total.
//  3 write (1,100),(1,80),(1,300),(2,0xFFFF) -> count=2; stream 0x0001012C, 0x0002FFFE, sentinel.
//  4 9 distinct writes with DEPTH=8 -> count=8, wr_drop pulses once; wr_en while busy -> wr_drop, count unchanged.
//  5 empty table, start@T -> sentinel @T+2, stream_done @T+4; clear+wr_en+start same cycle -> sentinel only.
//  6 rst asserted after 2nd toggle -> outputs reset at once, table empty; next start -> sentinel only.

Source files
------------

// File: rtl/score_record_streamer.sv
// Transmit side of the scoreboard record link: keeps a best-score-per-userid table and
// streams it as parity-toggle framed 32-bit words, ending with a sentinel score word.
module score_record_streamer #(
   parameter int          DEPTH      = 8,
   parameter int          GAP_CYCLES = 2,
   parameter logic [15:0] SENTINEL   = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [15:0] wr_userid,
   input  logic [15:0] wr_score,
   input  logic        clear,
   input  logic        start,
   output logic [31:0] data,
   output logic        parity_toggle,
   output logic        busy,
   output logic        stream_done,
   output logic        wr_drop,
   output logic [4:0]  count
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SNAP   = 3'd1,
      S_SEND   = 3'd2,
      S_HOLD   = 3'd3,
      S_TERM   = 3'd4,
      S_HOLD_T = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    uid_q   [DEPTH];
   logic [15:0]    uid_d   [DEPTH];
   logic [15:0]    score_q [DEPTH];
   logic [15:0]    score_d [DEPTH];
   logic [4:0]     count_q, count_d;
   logic [4:0]     n_q, n_d;
   logic [4:0]     k_q, k_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [31:0]    data_q, data_d;
   logic           par_q, par_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           drop_q, drop_d;

   logic           hit_s;
   logic [IW-1:0]  hit_idx_s;
   logic [15:0]    wr_score_s;
   logic           do_adv_s;
   logic           do_end_s;
   logic [4:0]     adv_k_s;
   logic [4:0]     adv_n_s;

   // Userid lookup among valid entries and sentinel clamping of incoming scores
   always_comb begin
      hit_s     = 1'b0;
      hit_idx_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((5'(i) < count_q) && (uid_q[i] == wr_userid)) begin
            hit_s     = 1'b1;
            hit_idx_s = IW'(i);
         end else begin
            hit_s     = hit_s;
         end
      end
      if (wr_score == SENTINEL) begin
         wr_score_s = SENTINEL - 16'd1;
      end else begin
         wr_score_s = wr_score;
      end
   end

   // Next-state, table update and output word selection
   always_comb begin
      state_d  = state_q;
      uid_d    = uid_q;
      score_d  = score_q;
      count_d  = count_q;
      n_d      = n_q;
      k_d      = k_q;
      gap_d    = gap_q;
      data_d   = data_q;
      par_d    = par_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      drop_d   = 1'b0;
      do_adv_s = 1'b0;
      do_end_s = 1'b0;
      adv_k_s  = k_q;
      adv_n_s  = n_q;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (clear) begin
               count_d = 5'd0;
            end else if (wr_en) begin
               if (hit_s) begin
                  if (wr_score_s > score_q[hit_idx_s]) begin
                     score_d[hit_idx_s] = wr_score_s;
                  end else begin
                     score_d[hit_idx_s] = score_q[hit_idx_s];
                  end
               end else if (count_q < 5'(DEPTH)) begin
                  uid_d[count_q[IW-1:0]]   = wr_userid;
                  score_d[count_q[IW-1:0]] = wr_score_s;
                  count_d                  = count_q + 5'd1;
               end else begin
                  drop_d = 1'b1;
               end
            end else begin
               count_d = count_q;
            end
            if (start) begin
               state_d = S_SNAP;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SNAP: begin
            n_d      = count_q;
            adv_n_s  = count_q;
            adv_k_s  = 5'd0;
            do_adv_s = 1'b1;
         end
         S_SEND: begin
            if (GAP_CYCLES == 1) begin
               do_adv_s = 1'b1;
            end else begin
               state_d = S_HOLD;
               gap_d   = GW'(GAP_CYCLES - 2);
            end
         end
         S_HOLD: begin
            if (gap_q == '0) begin
               do_adv_s = 1'b1;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         S_TERM: begin
            if (GAP_CYCLES == 1) begin
               do_end_s = 1'b1;
            end else begin
               state_d = S_HOLD_T;
               gap_d   = GW'(GAP_CYCLES - 2);
            end
         end
         S_HOLD_T: begin
            if (gap_q == '0) begin
               do_end_s = 1'b1;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // The table is frozen outside IDLE, so any write there is refused
      if ((state_q != S_IDLE) && wr_en) begin
         drop_d = 1'b1;
      end else begin
         drop_d = drop_d;
      end

      if (do_adv_s) begin
         par_d = ~par_q;
         if (adv_k_s < adv_n_s) begin
            state_d = S_SEND;
            data_d  = {uid_q[adv_k_s[IW-1:0]], score_q[adv_k_s[IW-1:0]]};
            k_d     = adv_k_s + 5'd1;
         end else begin
            state_d = S_TERM;
            data_d  = {16'h0000, SENTINEL};
         end
      end else begin
         par_d = par_d;
      end

      if (do_end_s) begin
         state_d = S_IDLE;
         done_d  = 1'b1;
      end else begin
         done_d = done_d;
      end
   end

   // State, table and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            uid_q[i]   <= 16'd0;
            score_q[i] <= 16'd0;
         end
         count_q <= 5'd0;
         n_q     <= 5'd0;
         k_q     <= 5'd0;
         gap_q   <= '0;
         data_q  <= 32'd0;
         par_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         uid_q   <= uid_d;
         score_q <= score_d;
         count_q <= count_d;
         n_q     <= n_d;
         k_q     <= k_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         par_q   <= par_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   assign data          = data_q;
   assign parity_toggle = par_q;
   assign busy          = busy_q;
   assign stream_done   = done_q;
   assign wr_drop       = drop_q;
   assign count         = count_q;

endmodule

// File: tb/tb_score_record_streamer.sv
// Directed and randomized checks of score_record_streamer against a queue-based table model.
module tb_score_record_streamer;

   localparam int G = 2;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wr_userid = 16'd0;
   logic [15:0] wr_score = 16'd0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [31:0] data;
   logic        parity_toggle;
   logic        busy;
   logic        stream_done;
   logic        wr_drop;
   logic [4:0]  count;

   int checks = 0;
   int failures = 0;
   logic [31:0] tbl[$];

   score_record_streamer #(.DEPTH(D), .GAP_CYCLES(G), .SENTINEL(16'hFFFF)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_userid(wr_userid), .wr_score(wr_score),
      .clear(clear), .start(start), .data(data), .parity_toggle(parity_toggle),
      .busy(busy), .stream_done(stream_done), .wr_drop(wr_drop), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference table: best score per userid in first-seen order, capacity D
   function automatic logic model_write(input logic [15:0] uid, input logic [15:0] sc_in);
      logic [15:0] sc;
      sc = (sc_in == 16'hFFFF) ? 16'hFFFE : sc_in;
      foreach (tbl[i]) begin
         if (tbl[i][31:16] == uid) begin
            if (sc > tbl[i][15:0]) tbl[i][15:0] = sc;
            return 1'b0;
         end
      end
      if (tbl.size() < D) begin
         tbl.push_back({uid, sc});
         return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic do_write(input logic [15:0] uid, input logic [15:0] sc);
      logic exp_drop;
      exp_drop  = model_write(uid, sc);
      wr_en     = 1'b1;
      wr_userid = uid;
      wr_score  = sc;
      step();
      wr_en = 1'b0;
      chk("wr_drop_after_write", 32'(wr_drop), 32'(exp_drop));
      chk("count_after_write", 32'(count), 32'(tbl.size()));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      tbl.delete();
      chk("count_after_clear", 32'(count), 32'd0);
   endtask

   task automatic run_stream(input bit do_clr, input bit do_wr, input logic [15:0] uid,
                             input logic [15:0] sc, input bit probe);
      logic [31:0] words[$];
      logic        exp_drop1;
      logic        prev_par;
      logic [31:0] prev_data;
      int n, last, off, tog;
      exp_drop1 = 1'b0;
      if (do_clr) tbl.delete();
      else if (do_wr) exp_drop1 = model_write(uid, sc);
      words = tbl;
      words.push_back(32'h0000FFFF);
      n    = tbl.size();
      last = 2 + (n + 1) * G;
      prev_par  = parity_toggle;
      prev_data = data;
      clear     = do_clr;
      wr_en     = do_wr;
      wr_userid = uid;
      wr_score  = sc;
      start     = 1'b1;
      step();
      clear = 1'b0;
      wr_en = 1'b0;
      start = 1'b0;
      off   = 1;
      tog   = 0;
      chk("snap_count", 32'(count), 32'(n));
      while (off <= last + 1) begin
         chk("busy", 32'(busy), 32'(off <= last));
         chk("stream_done", 32'(stream_done), 32'(off == last));
         chk("wr_drop_stream", 32'(wr_drop), (off == 1) ? 32'(exp_drop1) : 32'(probe && off == 4));
         if (parity_toggle !== prev_par) begin
            chk("toggle_time", 32'(off), 32'(2 + tog * G));
            if (tog <= n) chk("word", data, words[tog]);
            tog++;
         end else begin
            chk("data_hold", data, prev_data);
         end
         prev_par  = parity_toggle;
         prev_data = data;
         if (probe && off == 3) begin
            wr_en     = 1'b1;
            wr_userid = 16'($urandom);
            wr_score  = 16'($urandom);
         end else begin
            wr_en = 1'b0;
         end
         step();
         off++;
      end
      wr_en = 1'b0;
      chk("toggle_total", 32'(tog), 32'(n + 1));
      chk("count_after_stream", 32'(count), 32'(n));
   endtask

   initial begin
      int tg;
      logic pp;
      // Reset state
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_data", data, 32'd0);
      chk("rst_par", 32'(parity_toggle), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_done", 32'(stream_done), 32'd0);
      chk("rst_drop", 32'(wr_drop), 32'd0);

      // Mid-cycle asynchronous reset clears table at once
      do_write(16'd5, 16'd7);
      do_write(16'd6, 16'd8);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      #1 rst = 1'b0;
      tbl.delete();
      step();

      // Three distinct records streamed in insertion order
      do_write(16'd1, 16'd100);
      do_write(16'd2, 16'd250);
      do_write(16'd3, 16'd50);
      run_stream(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

      // Best-score merge and sentinel clamp
      do_clear();
      do_write(16'd1, 16'd100);
      do_write(16'd1, 16'd80);
      do_write(16'd1, 16'd300);
      do_write(16'd2, 16'hFFFF);
      run_stream(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

      // Full table drop, and write while busy
      do_clear();
      for (int i = 0; i < 9; i++) do_write(16'(10 + i), 16'(i * 3));
      run_stream(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);

      // Empty table, then clear+write+start together
      do_clear();
      run_stream(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      do_write(16'd9, 16'd9);
      run_stream(1'b1, 1'b1, 16'd4, 16'd44, 1'b0);

      // Reset after the second toggle of a stream
      do_write(16'd7, 16'd1);
      do_write(16'd8, 16'd2);
      pp = parity_toggle;
      start = 1'b1;
      step();
      start = 1'b0;
      tg = 0;
      for (int c = 0; c < 20 && tg < 2; c++) begin
         step();
         if (parity_toggle !== pp) tg++;
         pp = parity_toggle;
      end
      chk("abort_toggles_seen", 32'(tg), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("abort_data", data, 32'd0);
      chk("abort_par", 32'(parity_toggle), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_count", 32'(count), 32'd0);
      #1 rst = 1'b0;
      tbl.delete();
      step();
      run_stream(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

      // Randomized rounds against the model
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 2) == 0) do_clear();
         for (int w = 0; w < int'($urandom_range(0, 12)); w++) begin
            do_write(16'($urandom_range(0, 11)),
                     ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
         end
         run_stream(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 11)),
                    16'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
